// File: rtl/trdb_trigger_unit.sv
// Address-match trigger feeding the trace control block: arms on request, starts after N
// start-address hits, stops on a stop-address hit, window expiry or disarm.
module trdb_trigger_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             arm_i,
  input  logic             disarm_i,
  input  logic [XLEN-1:0]  start_addr_i,
  input  logic [XLEN-1:0]  stop_addr_i,
  input  logic [CNT_W-1:0] hit_count_i,
  input  logic [CNT_W-1:0] window_len_i,
  input  logic             inst_valid_i,
  input  logic [XLEN-1:0]  iaddr_i,
  output logic             trace_req_on_o,
  output logic             trace_req_off_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] hits_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [XLEN-1:0]  start_q, start_d;
  logic [XLEN-1:0]  stop_q, stop_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic             on_q, on_d;
  logic             off_q, off_d;

  logic             start_hit;
  logic             stop_hit;
  logic             arm_accept;
  logic [CNT_W-1:0] hits_inc;
  logic [CNT_W-1:0] win_inc;
  logic [CNT_W-1:0] hit_thresh;

  always_comb begin
    start_hit  = inst_valid_i && (iaddr_i == start_q);
    stop_hit   = inst_valid_i && (iaddr_i == stop_q);
    // disarm wins over arm, and an arm while tracing is dropped entirely
    arm_accept = arm_i && !disarm_i && (state_q != ACTIVE);
    hits_inc   = (hits_q == CNT_MAX) ? hits_q : hits_q + CNT_ONE;
    win_inc    = (win_q == CNT_MAX) ? win_q : win_q + CNT_ONE;
    hit_thresh = (hit_cnt_q == '0) ? CNT_ONE : hit_cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    stop_d    = stop_q;
    hit_cnt_d = hit_cnt_q;
    win_len_d = win_len_q;
    hits_d    = hits_q;
    win_d     = win_q;

    if (disarm_i) begin
      state_d = IDLE;
    end else if (arm_accept) begin
      start_d   = start_addr_i;
      stop_d    = stop_addr_i;
      hit_cnt_d = hit_count_i;
      win_len_d = window_len_i;
      hits_d    = '0;
      win_d     = '0;
      state_d   = ARMED;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (start_hit) begin
            hits_d = hits_inc;
            if (hits_inc >= hit_thresh) begin
              state_d = ACTIVE;
              win_d   = '0;
            end
          end
        end
        ACTIVE: begin
          // the terminating instruction is still counted as traced
          if (inst_valid_i) begin
            win_d = win_inc;
            if (stop_hit || ((win_len_q != '0) && (win_inc == win_len_q))) begin
              state_d = DONE;
            end
          end
        end
        default: ;
      endcase
    end

    on_d  = (state_d == ACTIVE);
    off_d = (state_q == ACTIVE) && (state_d != ACTIVE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      start_q   <= '0;
      stop_q    <= '0;
      hit_cnt_q <= '0;
      win_len_q <= '0;
      hits_q    <= '0;
      win_q     <= '0;
      on_q      <= 1'b0;
      off_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      hit_cnt_q <= hit_cnt_d;
      win_len_q <= win_len_d;
      hits_q    <= hits_d;
      win_q     <= win_d;
      on_q      <= on_d;
      off_q     <= off_d;
    end
  end

  assign trace_req_on_o  = on_q;
  assign trace_req_off_o = off_q;
  assign state_o         = state_q;
  assign hits_o          = hits_q;

endmodule

// File: tb/tb_trdb_trigger_unit.sv
// Self-checking bench for trdb_trigger_unit: directed scenarios plus random traffic
// compared against a rule-level reference model.
module tb_trdb_trigger_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             arm_i, disarm_i, inst_valid_i;
  logic [XLEN-1:0]  start_addr_i, stop_addr_i, iaddr_i;
  logic [CNT_W-1:0] hit_count_i, window_len_i;
  logic             trace_req_on_o, trace_req_off_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] hits_o;

  int tests_run = 0;
  int tests_failed = 0;
  int traced = 0;

  int          m_state, m_hits, m_win, m_hc, m_wl;
  logic [31:0] m_start, m_stop;
  logic        m_on, m_off;

  trdb_trigger_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .arm_i(arm_i), .disarm_i(disarm_i),
    .start_addr_i(start_addr_i), .stop_addr_i(stop_addr_i),
    .hit_count_i(hit_count_i), .window_len_i(window_len_i),
    .inst_valid_i(inst_valid_i), .iaddr_i(iaddr_i),
    .trace_req_on_o(trace_req_on_o), .trace_req_off_o(trace_req_off_o),
    .state_o(state_o), .hits_o(hits_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state = 0; m_hits = 0; m_win = 0; m_hc = 0; m_wl = 0;
    m_start = '0; m_stop = '0; m_on = 1'b0; m_off = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".state"}, {30'd0, state_o}, m_state);
    checkOutput({tag, ".hits"}, {16'd0, hits_o}, m_hits);
    checkOutput({tag, ".on"}, {31'd0, trace_req_on_o}, {31'd0, m_on});
    checkOutput({tag, ".off"}, {31'd0, trace_req_off_o}, {31'd0, m_off});
  endtask

  // Drives one cycle of inputs, advances the model by the rules, then checks after the edge.
  task automatic applyStimulus(input logic arm, input logic disarm, input logic valid,
                               input logic [31:0] addr, input string tag);
    int ns, nh, nw, thr;
    arm_i = arm; disarm_i = disarm; inst_valid_i = valid; iaddr_i = addr;
    ns = m_state; nh = m_hits; nw = m_win;
    if (disarm) begin
      ns = 0;
    end else if (arm && m_state != 2) begin
      m_start = start_addr_i; m_stop = stop_addr_i;
      m_hc = hit_count_i; m_wl = window_len_i;
      nh = 0; nw = 0; ns = 1;
    end else if (m_state == 1 && valid && addr == m_start) begin
      nh = (m_hits + 1 > CMAX) ? CMAX : m_hits + 1;
      thr = (m_hc == 0) ? 1 : m_hc;
      if (nh >= thr) begin ns = 2; nw = 0; end
    end else if (m_state == 2 && valid) begin
      nw = (m_win + 1 > CMAX) ? CMAX : m_win + 1;
      if (addr == m_stop || (m_wl != 0 && nw == m_wl)) ns = 3;
    end
    if (trace_req_on_o && valid) traced++;
    @(posedge clk_i);
    #1;
    m_off = (m_state == 2) && (ns != 2);
    m_on = (ns == 2);
    m_state = ns; m_hits = nh; m_win = nw;
    checkAll(tag);
  endtask

  task automatic setCfg(input logic [31:0] s, input logic [31:0] p, input int hc, input int wl);
    start_addr_i = s; stop_addr_i = p;
    hit_count_i = CNT_W'(hc); window_len_i = CNT_W'(wl);
  endtask

  function automatic logic [31:0] pickAddr();
    case ($urandom_range(0, 3))
      0: return 32'h1000;
      1: return 32'h2000;
      2: return 32'h3000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_ni = 1'b0;
    arm_i = 0; disarm_i = 0; inst_valid_i = 0; iaddr_i = '0;
    setCfg(32'h1000, 32'h2000, 1, 0);
    modelReset();
    #12;
    checkAll("reset");
    rst_ni = 1'b1;

    // basic start/stop
    applyStimulus(1, 0, 0, 0, "basic.arm");
    checkOutput("basic.armed", {30'd0, state_o}, 1);
    applyStimulus(0, 0, 1, 32'h1000, "basic.start");
    checkOutput("basic.on", {31'd0, trace_req_on_o}, 1);
    applyStimulus(0, 0, 1, 32'h2000, "basic.stop");
    checkOutput("basic.offpulse", {31'd0, trace_req_off_o}, 1);
    checkOutput("basic.done", {30'd0, state_o}, 3);
    applyStimulus(0, 0, 0, 0, "basic.hold");
    checkOutput("basic.offone", {31'd0, trace_req_off_o}, 0);

    // hit count of 3 with unrelated addresses interleaved
    setCfg(32'h1000, 32'h2000, 3, 0);
    applyStimulus(1, 0, 0, 0, "hc3.arm");
    applyStimulus(0, 0, 1, 32'h1000, "hc3.h1");
    checkOutput("hc3.hits1", {16'd0, hits_o}, 1);
    applyStimulus(0, 0, 1, 32'h1234, "hc3.x1");
    applyStimulus(0, 0, 1, 32'h1000, "hc3.h2");
    checkOutput("hc3.hits2", {16'd0, hits_o}, 2);
    checkOutput("hc3.armed", {30'd0, state_o}, 1);
    applyStimulus(0, 0, 1, 32'h0004, "hc3.x2");
    applyStimulus(0, 0, 1, 32'h1000, "hc3.h3");
    checkOutput("hc3.active", {30'd0, state_o}, 2);
    applyStimulus(0, 1, 0, 0, "hc3.disarm");

    // hit count 0 behaves as 1
    setCfg(32'h1000, 32'h2000, 0, 0);
    applyStimulus(1, 0, 0, 0, "hc0.arm");
    applyStimulus(0, 0, 1, 32'h1000, "hc0.h1");
    checkOutput("hc0.active", {30'd0, state_o}, 2);
    applyStimulus(0, 1, 0, 0, "hc0.disarm");

    // window of 4 with bubbles
    setCfg(32'h1000, 32'h2000, 1, 4);
    applyStimulus(1, 0, 0, 0, "win.arm");
    applyStimulus(0, 0, 1, 32'h1000, "win.start");
    traced = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 32'h500 + 32'(i), "win.inst");
      if (i < 3) checkOutput("win.stillon", {31'd0, trace_req_on_o}, 1);
      applyStimulus(0, 0, 0, 0, "win.bubble");
    end
    checkOutput("win.traced", traced, 4);
    checkOutput("win.done", {30'd0, state_o}, 3);

    // arm+disarm while active, then re-arm with a new start address
    setCfg(32'h1000, 32'h2000, 1, 0);
    applyStimulus(1, 0, 0, 0, "ad.arm");
    applyStimulus(0, 0, 1, 32'h1000, "ad.start");
    applyStimulus(1, 1, 0, 0, "ad.both");
    checkOutput("ad.idle", {30'd0, state_o}, 0);
    checkOutput("ad.offpulse", {31'd0, trace_req_off_o}, 1);
    applyStimulus(0, 0, 0, 0, "ad.hold");
    applyStimulus(1, 0, 0, 0, "ad.rearm");
    applyStimulus(0, 0, 1, 32'h1000, "ad.start2");
    applyStimulus(0, 0, 1, 32'h2000, "ad.stop2");
    setCfg(32'h3000, 32'h2000, 1, 0);
    applyStimulus(1, 0, 0, 0, "ad.newarm");
    start_addr_i = 32'h1000;
    applyStimulus(0, 0, 1, 32'h1000, "ad.old");
    checkOutput("ad.oldignored", {30'd0, state_o}, 1);
    applyStimulus(0, 0, 1, 32'h3000, "ad.new");
    checkOutput("ad.newfires", {30'd0, state_o}, 2);
    applyStimulus(0, 1, 0, 0, "ad.disarm");

    // start == stop
    setCfg(32'h1000, 32'h1000, 1, 0);
    applyStimulus(1, 0, 0, 0, "eq.arm");
    applyStimulus(0, 0, 1, 32'h1000, "eq.first");
    checkOutput("eq.active", {30'd0, state_o}, 2);
    applyStimulus(0, 0, 1, 32'h1000, "eq.second");
    checkOutput("eq.done", {30'd0, state_o}, 3);
    checkOutput("eq.offpulse", {31'd0, trace_req_off_o}, 1);

    // asynchronous reset mid-ACTIVE
    setCfg(32'h1000, 32'h2000, 1, 0);
    applyStimulus(1, 0, 0, 0, "rst.arm");
    applyStimulus(0, 0, 1, 32'h1000, "rst.start");
    #2 rst_ni = 1'b0;
    #1;
    modelReset();
    checkAll("rst.async");
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(0, 0, 0, 0, "rst.after");
    checkOutput("rst.nooff", {31'd0, trace_req_off_o}, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      setCfg(pickAddr(), pickAddr(), $urandom_range(0, 3), $urandom_range(0, 6));
      applyStimulus(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 70), pickAddr(), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
